// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO pop port plus UART TX pin and status for the drain stage
interface fifo_uart_tx_if #(parameter int WIDTH = 8);
  logic             en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_pop_data;
  logic             fifo_pop_en;
  logic             tx;
  logic             busy;
  logic             frame_done;
  modport master (input en, fifo_empty, fifo_pop_data, output fifo_pop_en, tx, busy, frame_done);
  modport slave (output en, fifo_empty, fifo_pop_data, input fifo_pop_en, tx, busy, frame_done);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and serialises each as a start/data/stop UART frame
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_uart_tx_if.master  bus
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             fifo_pop_en_q, fifo_pop_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             go, baud_end;
  // Next state, counters and the output values registered one cycle behind the state
  always_comb begin
    go       = bus.en && !bus.fifo_empty;
    baud_end = baud_q == BAUD_LAST;
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    if (state_q == START || state_q == DATA || state_q == STOP)
      baud_d = baud_end ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE:  state_d = go ? POP : IDLE;
      POP:   state_d = LOAD;
      LOAD: begin
        shift_d = bus.fifo_pop_data;
        state_d = START;
      end
      START: state_d = baud_end ? DATA : START;
      DATA: if (baud_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q == DATA_LAST ? '0 : bit_q + CW'(1);
        state_d = bit_q == DATA_LAST ? STOP : DATA;
      end
      STOP: if (baud_end) begin
        bit_d   = bit_q == STOP_LAST ? '0 : bit_q + CW'(1);
        state_d = bit_q != STOP_LAST ? STOP : go ? POP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_d          = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    fifo_pop_en_d = state_d == POP;
    // busy lags the state by one cycle so it also covers the delayed final stop cycle on tx
    busy_d        = state_q != IDLE;
    frame_done_d  = state_q == STOP && baud_end && bit_q == STOP_LAST;
  end
  // State and output registers; reset parks the line high and abandons any partial frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      tx_q          <= 1'b1;
      fifo_pop_en_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      fifo_pop_en_q <= fifo_pop_en_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  assign bus.tx          = tx_q;
  assign bus.fifo_pop_en = fifo_pop_en_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of the FIFO-draining UART transmitter
module tb_fifo_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fifo_uart_tx_if #(.WIDTH(8)) b();
  fifo_uart_tx_if #(.WIDTH(8)) b2();
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  logic [7:0] q1[$], q2[$];
  logic push1, push2, pe1, pe2;
  logic [7:0] pd1, pd2;
  int pops1 = 0, pops2 = 0, fd1 = 0, fd2 = 0;
  int errors = 0, checks = 0;
  // Sample DUT strobes mid-cycle to avoid racing the active edge
  always @(negedge clk) begin
    pe1 = b.fifo_pop_en;
    pe2 = b2.fifo_pop_en;
    if (b.fifo_pop_en) pops1++;
    if (b2.fifo_pop_en) pops2++;
    if (b.frame_done) fd1++;
    if (b2.frame_done) fd2++;
  end
  // FIFO models: pop data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (pe1 === 1'b1 && q1.size() > 0) begin b.fifo_pop_data <= q1[0]; q1.delete(0); end
    if (pe2 === 1'b1 && q2.size() > 0) begin b2.fifo_pop_data <= q2[0]; q2.delete(0); end
    if (push1 === 1'b1) q1.push_back(pd1);
    if (push2 === 1'b1) q2.push_back(pd2);
    b.fifo_empty  <= q1.size() == 0;
    b2.fifo_empty <= q2.size() == 0;
  end
  function automatic logic txs(input bit u2);
    return u2 ? b2.tx : b.tx;
  endfunction
  function automatic logic bsy(input bit u2);
    return u2 ? b2.busy : b.busy;
  endfunction
  function automatic logic fdo(input bit u2);
    return u2 ? b2.frame_done : b.frame_done;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input bit u2, input logic [7:0] d);
    if (u2) begin push2 = 1'b1; pd2 = d; end else begin push1 = 1'b1; pd1 = d; end
    @(negedge clk);
    push1 = 1'b0;
    push2 = 1'b0;
  endtask
  // Waits for a start bit, then checks every cycle of the frame; hi = high cycles seen before it
  task automatic check_frame(input bit u2, input logic [7:0] d, input int nstop, input int drop, output int hi);
    int total, bi, txbad, fdbad, bbad;
    logic [7:0] got, sh;
    logic e;
    hi = 0;
    for (int i = 0; i < 60 && txs(u2) !== 1'b0; i++) begin
      @(negedge clk);
      if (txs(u2) !== 1'b0) hi++;
    end
    chk("start bit seen", txs(u2), 0);
    total = (9 + nstop) * CPB;
    txbad = 0; fdbad = 0; bbad = 0; got = '0;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop) b.en = 1'b0;
      bi = k / CPB;
      sh = d >> (bi > 0 ? bi - 1 : 0);
      e  = bi == 0 ? 1'b0 : bi <= 8 ? sh[0] : 1'b1;
      if (txs(u2) !== e) txbad++;
      if (fdo(u2) !== (k == total - 1)) fdbad++;
      if (bsy(u2) !== 1'b1) bbad++;
      if (bi >= 1 && bi <= 8 && k % CPB == CPB / 2) got = {txs(u2), got[7:1]};
    end
    chk("tx frame bits", txbad, 0);
    chk("frame_done timing", fdbad, 0);
    chk("busy during frame", bbad, 0);
    chk("received byte", got, d);
  endtask
  initial begin
    int hi, p0, f0, bad;
    b.en = 1'b0; b2.en = 1'b0;
    push1 = 1'b0; push2 = 1'b0; pd1 = '0; pd2 = '0;
    repeat (3) @(negedge clk);
    chk("reset tx", b.tx, 1);
    chk("reset busy", b.busy, 0);
    chk("reset pop_en", b.fifo_pop_en, 0);
    chk("reset frame_done", b.frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // single byte 0xA5
    p0 = pops1; f0 = fd1;
    b.en = 1'b1;
    push(0, 8'hA5);
    check_frame(0, 8'hA5, 1, -1, hi);
    repeat (2) @(negedge clk);
    chk("A5 pop count", pops1 - p0, 1);
    chk("A5 frame_done count", fd1 - f0, 1);
    chk("A5 busy after", b.busy, 0);
    chk("A5 tx idle", b.tx, 1);
    // reset in the middle of a data bit
    p0 = pops1;
    push(0, 8'h5A);
    for (int i = 0; i < 40 && b.tx !== 1'b0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("busy before reset", b.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset tx", b.tx, 1);
    chk("async reset busy", b.busy, 0);
    chk("async reset pop_en", b.fifo_pop_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (b.tx !== 1'b1 || b.busy !== 1'b0) bad++;
    end
    chk("idle after reset", bad, 0);
    chk("reset pop count", pops1 - p0, 1);
    // back-to-back 0x00 then 0xFF
    p0 = pops1;
    push(0, 8'h00);
    push(0, 8'hFF);
    check_frame(0, 8'h00, 1, -1, hi);
    check_frame(0, 8'hFF, 1, -1, hi);
    chk("b2b gap cycles", hi, 2);
    repeat (3) @(negedge clk);
    chk("b2b pop count", pops1 - p0, 2);
    chk("b2b busy after", b.busy, 0);
    // empty FIFO with en held high
    p0 = pops1; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (b.tx !== 1'b1 || b.busy !== 1'b0) bad++;
    end
    chk("empty no pop", pops1 - p0, 0);
    chk("empty line idle", bad, 0);
    // en dropped during data of 0x3C with 0x11 queued
    b.en = 1'b0;
    push(0, 8'h3C);
    push(0, 8'h11);
    p0 = pops1;
    b.en = 1'b1;
    check_frame(0, 8'h3C, 1, 12, hi);
    repeat (6) @(negedge clk);
    chk("en drop pop count", pops1 - p0, 1);
    chk("en drop busy", b.busy, 0);
    chk("en drop tx idle", b.tx, 1);
    b.en = 1'b1;
    check_frame(0, 8'h11, 1, -1, hi);
    chk("resume pop count", pops1 - p0, 2);
    // two stop bits, byte 0x81
    p0 = pops2; f0 = fd2;
    b2.en = 1'b1;
    push(1, 8'h81);
    check_frame(1, 8'h81, 2, -1, hi);
    repeat (2) @(negedge clk);
    chk("2stop pop count", pops2 - p0, 1);
    chk("2stop frame_done count", fd2 - f0, 1);
    chk("2stop busy after", b2.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
